// File: rtl/clock_key_pio_if.sv
// Avalon-MM slave bus bundle for clock_key_pio: word address, select, write strobe and data.
// readdata is returned combinationally by the slave.
interface clock_key_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/clock_key_pio.sv
// Key/switch PIO: per-bit 2-flop sync, optional debounce, sticky edge capture and masked level IRQ.
// Registers: 0 DATA (debounced), 1 IRQMASK, 2 reserved, 3 EDGECAP (write-1-to-clear).
module clock_key_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   clock_key_pio_if.slave   bus,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] db;
   logic [WIDTH-1:0] db_d;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] evt;
   logic [WIDTH-1:0] clr;
   logic             wr_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_nodb
         assign db = sync2;
      end else begin : g_db
         localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
         localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
         logic [CW-1:0]    cnt [WIDTH];
         logic [WIDTH-1:0] db_r;

         // Counter only runs while the synchronized level differs from db, so it cannot wrap.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               db_r <= '0;
               for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
            end else begin
               for (int unsigned i = 0; i < WIDTH; i++) begin
                  if (sync2[i] == db_r[i]) begin
                     cnt[i] <= '0;
                  end else if (cnt[i] == LAST) begin
                     db_r[i] <= sync2[i];
                     cnt[i]  <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + 1'b1;
                  end
               end
            end
         end

         assign db = db_r;
      end
   endgenerate

   assign rise  = db & ~db_d;
   assign fall  = ~db & db_d;
   assign wr_en = bus.chipselect & ~bus.write_n;

   always_comb begin
      case (EDGE_TYPE)
         0:       evt = rise;
         1:       evt = fall;
         default: evt = rise | fall;
      endcase
   end

   always_comb begin
      clr = '0;
      if (wr_en && bus.address == 2'd3) clr = bus.writedata[WIDTH-1:0];
   end

   // OR-ing the event after masking the clear makes a coincident set win.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_d    <= '0;
         irqmask <= '0;
         edgecap <= '0;
      end else begin
         db_d    <= db;
         edgecap <= (edgecap & ~clr) | evt;
         if (wr_en && bus.address == 2'd1) irqmask <= bus.writedata[WIDTH-1:0];
      end
   end

   assign irq = |(edgecap & irqmask);

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         2'd0:    bus.readdata[WIDTH-1:0] = db;
         2'd1:    bus.readdata[WIDTH-1:0] = irqmask;
         2'd3:    bus.readdata[WIDTH-1:0] = edgecap;
         default: bus.readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_clock_key_pio.sv
// Directed bench for clock_key_pio: table of per-cycle vectors plus hand sequences for
// set/clear collision, mask timing, reset mid-debounce and any-edge capture.
module tb_clock_key_pio;

   logic        clk;
   logic        reset_n;
   logic [3:0]  in_port;
   logic [1:0]  b_addr;
   logic        b_cs;
   logic        b_wn;
   logic [31:0] b_wd;
   logic        irq0;
   logic        irq2;
   logic [31:0] rd0;
   logic [31:0] rd2;

   int n_checks = 0;
   int n_fail   = 0;

   clock_key_pio_if bus0 ();
   clock_key_pio_if bus2 ();

   assign bus0.address    = b_addr;
   assign bus0.chipselect = b_cs;
   assign bus0.write_n    = b_wn;
   assign bus0.writedata  = b_wd;
   assign bus2.address    = b_addr;
   assign bus2.chipselect = b_cs;
   assign bus2.write_n    = b_wn;
   assign bus2.writedata  = b_wd;
   assign rd0 = bus0.readdata;
   assign rd2 = bus2.readdata;

   clock_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0)
   );

   clock_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port), .irq(irq2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  in_v;
      logic [1:0]  addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] i, input logic [1:0] a, input logic w,
                      input logic [31:0] wd, input logic [31:0] rd, input logic q, input int n);
      for (int r = 0; r < n; r++) vecs.push_back('{i, a, w, wd, rd, q});
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic setbus(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
      b_cs   = cs;
      b_wn   = wn;
      b_addr = a;
      b_wd   = wd;
   endtask

   initial begin
      reset_n = 1'b0;
      in_port = 4'h0;
      setbus(1'b0, 1'b1, 2'd0, 32'h0);

      // in, addr, wr, wdata, expected readdata, expected irq, repeat
      add(4'h0, 2'd0, 1'b1, 32'h1, 32'h0, 1'b0, 1);
      vecs[0].addr = 2'd1;
      vecs[0].exp_rd = 32'h1;
      add(4'h1, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 5);
      add(4'h1, 2'd0, 1'b0, 32'h0, 32'h1, 1'b0, 1);
      add(4'h1, 2'd3, 1'b0, 32'h0, 32'h1, 1'b1, 1);
      add(4'h5, 2'd0, 1'b0, 32'h0, 32'h1, 1'b1, 3);
      add(4'h1, 2'd0, 1'b0, 32'h0, 32'h1, 1'b1, 6);
      add(4'h1, 2'd3, 1'b0, 32'h0, 32'h1, 1'b1, 1);
      add(4'h5, 2'd0, 1'b0, 32'h0, 32'h1, 1'b1, 5);
      add(4'h5, 2'd0, 1'b0, 32'h0, 32'h5, 1'b1, 1);
      add(4'h5, 2'd3, 1'b0, 32'h0, 32'h5, 1'b1, 1);
      add(4'h5, 2'd3, 1'b1, 32'h1, 32'h4, 1'b0, 1);
      add(4'h5, 2'd3, 1'b0, 32'h0, 32'h4, 1'b0, 1);

      tick(2);
      for (int a = 0; a < 4; a++) begin
         b_addr = 2'(a);
         #1;
         check($sformatf("reset_reg%0d", a), rd0, 32'h0);
      end
      check("reset_irq", {31'h0, irq0}, 32'h0);

      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         in_port = vecs[i].in_v;
         setbus(1'b1, ~vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         tick(1);
         check($sformatf("vec%0d_rd", i), rd0, vecs[i].exp_rd);
         check($sformatf("vec%0d_irq", i), {31'h0, irq0}, {31'h0, vecs[i].exp_irq});
      end

      // Falling edge on bit 0 is not captured; then a clear collides with a fresh rise.
      in_port = 4'h4;
      setbus(1'b1, 1'b1, 2'd3, 32'h0);
      tick(8);
      check("fall_not_captured", rd0, 32'h4);
      in_port = 4'h5;
      tick(6);
      check("pre_collision", rd0, 32'h4);
      setbus(1'b1, 1'b0, 2'd3, 32'h1);
      tick(1);
      check("set_wins", rd0, 32'h5);
      check("set_wins_irq", {31'h0, irq0}, 32'h1);
      setbus(1'b1, 1'b1, 2'd3, 32'h0);
      tick(3);
      check("sticky", rd0, 32'h5);

      // Mask timing, ignored writes, reserved read, chipselect-independent read.
      reset_n = 1'b0;
      in_port = 4'h8;
      tick(2);
      reset_n = 1'b1;
      tick(7);
      check("cap_bit3", rd0, 32'h8);
      check("masked_irq", {31'h0, irq0}, 32'h0);
      setbus(1'b1, 1'b0, 2'd1, 32'h8);
      #1;
      check("irq_before_mask_edge", {31'h0, irq0}, 32'h0);
      tick(1);
      check("irq_after_mask_edge", {31'h0, irq0}, 32'h1);
      setbus(1'b1, 1'b0, 2'd0, 32'hF);
      tick(1);
      setbus(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF);
      tick(1);
      setbus(1'b1, 1'b1, 2'd0, 32'h0);
      #1;
      check("data_write_ignored", rd0, 32'h8);
      b_addr = 2'd2;
      #1;
      check("reserved_reads_0", rd0, 32'h0);
      setbus(1'b0, 1'b1, 2'd1, 32'h0);
      #1;
      check("read_without_cs", rd0, 32'h8);

      // Reset mid-debounce with all inputs high.
      in_port = 4'hF;
      setbus(1'b1, 1'b1, 2'd3, 32'h0);
      tick(3);
      reset_n = 1'b0;
      #1;
      check("async_rst_edgecap", rd0, 32'h0);
      check("async_rst_irq", {31'h0, irq0}, 32'h0);
      b_addr = 2'd1;
      #1;
      check("async_rst_mask", rd0, 32'h0);
      b_addr = 2'd0;
      #1;
      check("async_rst_data", rd0, 32'h0);
      tick(2);
      reset_n = 1'b1;
      b_addr = 2'd3;
      tick(6);
      check("post_rst_k5_cap", rd0, 32'h0);
      b_addr = 2'd0;
      #1;
      check("post_rst_k5_data", rd0, 32'hF);
      b_addr = 2'd3;
      tick(1);
      check("post_rst_k6_cap", rd0, 32'hF);
      check("post_rst_irq", {31'h0, irq0}, 32'h0);

      // Any-edge capture on the EDGE_TYPE=2 instance, cleared between the two edges.
      reset_n = 1'b0;
      in_port = 4'h0;
      tick(2);
      reset_n = 1'b1;
      tick(3);
      in_port = 4'h2;
      tick(6);
      check("any_rise_k5", rd2, 32'h0);
      tick(1);
      check("any_rise_k6", rd2, 32'h2);
      tick(2);
      setbus(1'b1, 1'b0, 2'd3, 32'h2);
      tick(1);
      check("any_cleared", rd2, 32'h0);
      setbus(1'b1, 1'b1, 2'd3, 32'h0);
      in_port = 4'h0;
      tick(6);
      check("any_fall_k5", rd2, 32'h0);
      tick(1);
      check("any_fall_k6", rd2, 32'h2);
      check("rising_only_ignores_fall", rd0, 32'h0);
      tick(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
